uart_rx_fifo_ctrl: RTL and testbench
====================================

Name: uart_rx_fifo_ctrl

Overview:
Parametrised receive-side buffer between the UART receiver and the consumer logic (CPU/display FSM).
- Converts level-style `rx_ready` and `read` strobes into single-cycle push/pop events.
- Holds the words in an internal synchronous FIFO; no vendor IP.
- Reports occupancy plus sticky overflow/underflow error flags.

Parameters:
- DATA_W, 8, width of received word and `data_out`.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- AF_MARGIN, 2, `almost_full` asserts when count >= DEPTH-AF_MARGIN; range 0..DEPTH-1.
- SHOW_AHEAD, 0, selects read mode. 0 = `data_out` registered on pop. 1 = `data_out` always shows head word.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rx_ready  in  1  receiver word-valid level; each rising edge = one push.
- rx_data  in  DATA_W  received word; sampled on the push edge.
- read  in  1  consumer read level; each rising edge = one pop.
- clear_flags  in  1  clears `overflow` and `underflow`.
- data_out  out  DATA_W  read data.
- data_valid  out  1  one-cycle pulse; `data_out` updated by an accepted pop.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= DEPTH-AF_MARGIN.
- count  out  clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky; a push was dropped.
- underflow  out  1  sticky; a pop was rejected.

Behaviour:
- **Reset** (synchronous, `rst` high at a clk edge):
  - Pointers 0, count 0, `empty`=1, `full`=0, `almost_full`=(AF_MARGIN==DEPTH... i.e. 0 unless DEPTH-AF_MARGIN==0).
  - `data_out`=0, `data_valid`=0, `overflow`=0, `underflow`=0.
  - Edge registers `rx_q` and `rd_q` reset to 1. A level held high through reset does not cause a push or pop; it must fall and rise again.
  - Reset mid-operation discards all contents immediately.
- **Edge detect:** `push_req = rx_ready & ~rx_q`; `pop_req = read & ~rd_q`. `rx_q` and `rd_q` track their inputs every cycle.
  - One event per rising edge regardless of high duration.
  - Back-to-back events need at least one low cycle between them.
- **Push** accepted at edge E if `push_req` and (!full or pop accepted same edge).
  - `rx_data` is written to `mem[wr_ptr]` and `wr_ptr` wraps modulo DEPTH.
  - If `push_req` and full and no pop: word dropped, `overflow`<=1, no state change.
- **Pop** accepted at edge E if `pop_req` and !empty.
  - `rd_ptr` wraps modulo DEPTH.
  - `data_valid`<=1 for exactly one cycle after E.
  - If `pop_req` and empty: `underflow`<=1, no pointer change, `data_valid` stays 0. This holds even if a push occurs the same edge; the push is still accepted.
- **Simultaneous** accepted push and pop: count unchanged. At full both are accepted; at empty only the push is accepted.
- **count:** +1 on push only, -1 on pop only, unchanged otherwise.
  - `empty`, `full`, `almost_full` are registered and consistent with `count` in the same cycle (latency 1 from the event edge).
- **SHOW_AHEAD=0:** at an accepted pop edge, `data_out`<=`mem[rd_ptr]`. `data_out` holds its value otherwise.
- **SHOW_AHEAD=1:** `data_out` = `mem[rd_ptr]` combinationally; undefined content while empty (bench must not check it). `data_valid` still pulses after each pop.
- **Flags:** `clear_flags` clears `overflow`/`underflow`; a set event on the same edge wins (flag remains 1).
- **Latency:** push edge to `empty`=0 is 1 cycle. Pop edge to `data_out`/`data_valid` is 1 cycle (SHOW_AHEAD=0).

Decomposition:
- Shared package `uart_pkg`:
  - Default DATA_W/DEPTH constants.
  - `clog2` function.
  - Read-mode constants `RD_REGISTERED`=0 and `RD_SHOW_AHEAD`=1.
- One sub-module `sync_fifo` (DATA_W, DEPTH, SHOW_AHEAD):
  - Memory, pointers, count and flags with `wr_en`/`rd_en` inputs.
- The top holds the edge detectors, accept logic and sticky error flags.

Test Plan:
1. **Reset with levels high.** Hold rst with `rx_ready`=1, `read`=1 for 3 cycles, release with both still high. Expect `empty`=1, count=0 and no `data_valid` for 5 cycles. All outputs at reset values.
2. **Single push/pop** (SHOW_AHEAD=0). Pulse `rx_ready` with `rx_data`=0x41, then pulse `read`. Expect count 0→1→0, `data_out`=0x41 one cycle after the read edge, `data_valid` high exactly 1 cycle.
3. **Fill and overflow** (DEPTH=4, AF_MARGIN=1). Push 0x10..0x14. Expect `almost_full` at count=3, `full` at count=4, fifth word dropped, `overflow`=1. Pops return 0x10,0x11,0x12,0x13.
4. **Underflow and clear.** Pop while empty → `underflow`=1, count=0. Assert `clear_flags` alone → 0. Repeat with `clear_flags` and an empty pop on the same edge → `underflow` stays 1.
5. **Simultaneous at full** (DEPTH=4). Push and pop edges coincide. Expect count stays 4, oldest word out, new word queued last. Then pointer wrap verified by draining 8 sequential words 0x00..0x07 in order across two fills.
6. **SHOW_AHEAD=1.** Push 0xA5, 0x5A. Expect `data_out`=0xA5 with no pop. After a pop edge, `data_out`=0x5A and `data_valid` pulses once.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and helpers for the UART receive buffer
package uart_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    localparam int RD_REGISTERED = 0;
    localparam int RD_SHOW_AHEAD = 1;

    // Ceiling log2 for sizing pointers; returns 1 for values below 2.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered occupancy flags
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_MARGIN  = 2,
    parameter int SHOW_AHEAD = RD_REGISTERED
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      data_out,
    output logic [clog2(DEPTH):0]  count,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;

    // Occupancy after this edge; flags are registered from it so they line up with count.
    always_comb begin
        count_nxt = count;
        if (wr_en && !rd_en) begin
            count_nxt = count + CW'(1);
        end else if (!wr_en && rd_en) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage array; contents are not reset, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, count and flags; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= (AF_LVL == '0);
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == FULL_LVL);
            almost_full <= (count_nxt >= AF_LVL);
        end
    end

    generate
        if (SHOW_AHEAD == RD_SHOW_AHEAD) begin : g_show_ahead
            assign data_out = mem[rd_ptr];
        end else begin : g_registered
            logic [DATA_W-1:0] data_q;
            // Output word captured only when a pop is accepted, held otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                end else if (rd_en) begin
                    data_q <= mem[rd_ptr];
                end
            end
            assign data_out = data_q;
        end
    endgenerate

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// rtl/uart_rx_fifo_ctrl.sv - edge-triggered receive buffer with sticky error flags
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_MARGIN  = 2,
    parameter int SHOW_AHEAD = RD_REGISTERED
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_ready,
    input  logic [DATA_W-1:0]      rx_data,
    input  logic                   read,
    input  logic                   clear_flags,
    output logic [DATA_W-1:0]      data_out,
    output logic                   data_valid,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic [clog2(DEPTH):0]  count,
    output logic                   overflow,
    output logic                   underflow
);

    logic rx_q;
    logic rd_q;
    logic push_req;
    logic pop_req;
    logic push_acc;
    logic pop_acc;

    assign push_req = rx_ready & ~rx_q;
    assign pop_req  = read & ~rd_q;
    // A pop frees a slot on the same edge, so a push at full still fits.
    assign pop_acc  = pop_req & ~empty;
    assign push_acc = push_req & (~full | pop_acc);

    // Edge registers start high so a level held through reset needs a fresh rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q <= 1'b1;
            rd_q <= 1'b1;
        end else begin
            rx_q <= rx_ready;
            rd_q <= read;
        end
    end

    // Pop strobe plus sticky error flags; a set event beats a same-edge clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            data_valid <= pop_acc;
            if (push_req && !push_acc) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (pop_req && empty) begin
                underflow <= 1'b1;
            end else if (clear_flags) begin
                underflow <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .AF_MARGIN  (AF_MARGIN),
        .SHOW_AHEAD (SHOW_AHEAD)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (push_acc),
        .wr_data     (rx_data),
        .rd_en       (pop_acc),
        .data_out    (data_out),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb/tb_uart_rx_fifo_ctrl.sv - randomized and directed check against a queue model
module tb_uart_rx_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFM   = 1;

    logic          clk;
    logic          rst;
    logic          rx_ready;
    logic [DW-1:0] rx_data;
    logic          read;
    logic          clear_flags;

    logic [DW-1:0] dout0, dout1;
    logic          dv0, dv1, emp0, emp1, ful0, ful1, af0, af1, ovf0, ovf1, unf0, unf1;
    logic [2:0]    cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DW-1:0] mq[$];
    logic          m_ovf, m_unf, m_dv, m_prx, m_prd;
    logic [DW-1:0] m_dout;

    uart_rx_fifo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM), .SHOW_AHEAD(0)) dut_reg (
        .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data), .read(read),
        .clear_flags(clear_flags), .data_out(dout0), .data_valid(dv0), .empty(emp0),
        .full(ful0), .almost_full(af0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    uart_rx_fifo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM), .SHOW_AHEAD(1)) dut_sa (
        .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data), .read(read),
        .clear_flags(clear_flags), .data_out(dout1), .data_valid(dv1), .empty(emp1),
        .full(ful1), .almost_full(af1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the behavioural rules for one clock edge using the current inputs.
    task automatic model_edge();
        bit push, pop, push_ok, pop_ok;
        int sz;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_dv = 0; m_dout = '0; m_prx = 1; m_prd = 1;
        end else begin
            sz      = mq.size();
            push    = rx_ready && !m_prx;
            pop     = read && !m_prd;
            pop_ok  = pop && (sz > 0);
            push_ok = push && ((sz < DEPTH) || pop_ok);
            m_dv    = pop_ok;
            if (pop_ok) m_dout = mq.pop_front();
            if (push_ok) mq.push_back(rx_data);
            if (push && !push_ok) m_ovf = 1; else if (clear_flags) m_ovf = 0;
            if (pop && sz == 0) m_unf = 1; else if (clear_flags) m_unf = 0;
            m_prx = rx_ready;
            m_prd = read;
        end
    endtask

    task automatic compare_all();
        int n;
        n = mq.size();
        check("count_reg", 32'(cnt0), 32'(n));
        check("count_sa", 32'(cnt1), 32'(n));
        check("empty", {31'b0, emp0}, {31'b0, n == 0});
        check("empty_sa", {31'b0, emp1}, {31'b0, n == 0});
        check("full", {31'b0, ful0}, {31'b0, n == DEPTH});
        check("almost_full", {31'b0, af0}, {31'b0, n >= DEPTH - AFM});
        check("almost_full_sa", {31'b0, af1}, {31'b0, n >= DEPTH - AFM});
        check("overflow", {31'b0, ovf0}, {31'b0, m_ovf});
        check("underflow", {31'b0, unf0}, {31'b0, m_unf});
        check("underflow_sa", {31'b0, unf1}, {31'b0, m_unf});
        check("data_valid", {31'b0, dv0}, {31'b0, m_dv});
        check("data_valid_sa", {31'b0, dv1}, {31'b0, m_dv});
        check("data_out_reg", 32'(dout0), 32'(m_dout));
        if (n > 0) check("data_out_sa", 32'(dout1), 32'(mq[0]));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic push(input logic [DW-1:0] d);
        rx_ready = 1; rx_data = d; cyc();
        rx_ready = 0; cyc();
    endtask

    task automatic pop();
        read = 1; cyc();
        read = 0; cyc();
    endtask

    initial begin
        rst = 1; rx_ready = 1; read = 1; rx_data = '0; clear_flags = 0;
        // reset with both levels held high
        repeat (3) cyc();
        rst = 0;
        repeat (5) cyc();
        check("reset_count", 32'(cnt0), 32'd0);
        rx_ready = 0; read = 0;
        cyc();

        // single push / pop
        push(8'h41);
        check("single_count", 32'(cnt0), 32'd1);
        read = 1; cyc();
        check("single_dout", 32'(dout0), 32'h41);
        check("single_dv", {31'b0, dv0}, 32'd1);
        read = 0; cyc();
        check("single_dv_drop", {31'b0, dv0}, 32'd0);

        // fill and overflow
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        check("fill_ovf", {31'b0, ovf0}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            pop();
            check("drain_word", 32'(dout0), 32'(8'h10 + i));
        end

        // underflow and clear
        pop();
        check("unf_set", {31'b0, unf0}, 32'd1);
        clear_flags = 1; cyc(); clear_flags = 0; cyc();
        check("unf_clear", {31'b0, unf0}, 32'd0);
        read = 1; clear_flags = 1; cyc(); read = 0; clear_flags = 0; cyc();
        check("unf_set_wins", {31'b0, unf0}, 32'd1);
        clear_flags = 1; cyc(); clear_flags = 0; cyc();

        // simultaneous push and pop at full
        for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
        rx_ready = 1; read = 1; rx_data = 8'h99; cyc();
        rx_ready = 0; read = 0; cyc();
        check("simul_count", 32'(cnt0), 32'd4);
        check("simul_oldest", 32'(dout0), 32'h20);
        check("simul_no_ovf", {31'b0, ovf0}, 32'd0);
        for (int i = 0; i < 4; i++) pop();
        check("simul_last", 32'(dout0), 32'h99);

        // pointer wrap across two fills
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) push(8'(f * 4 + i));
            for (int i = 0; i < 4; i++) begin
                pop();
                check("wrap_word", 32'(dout0), 32'(f * 4 + i));
            end
        end

        // show-ahead head word
        push(8'hA5); push(8'h5A);
        check("sa_head", 32'(dout1), 32'hA5);
        read = 1; cyc();
        check("sa_next", 32'(dout1), 32'h5A);
        check("sa_dv", {31'b0, dv1}, 32'd1);
        read = 0; cyc();
        pop();

        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            rx_ready    = ($urandom_range(0, 1) == 1);
            read        = ($urandom_range(0, 2) == 0);
            rx_data     = 8'($urandom);
            clear_flags = ($urandom_range(0, 15) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
